// File: rtl/owr_pkg.sv
// Shared opcodes, response codes and FSM state type for the UART-to-1-Wire command bridge.
package owr_pkg;

   localparam logic [7:0] OP_RESET      = 8'h01;
   localparam logic [7:0] OP_WRITE      = 8'h02;
   localparam logic [7:0] OP_READ       = 8'h03;
   localparam logic [7:0] OP_WRITE_BITS = 8'h04;
   localparam logic [7:0] OP_READ_BITS  = 8'h05;

   localparam logic [7:0] RSP_ACK = 8'hAA;
   localparam logic [7:0] RSP_ERR = 8'hEE;

   localparam int unsigned BITS_W = 5;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_ARG,
      ST_ISSUE,
      ST_WAIT_DONE,
      ST_SEND
   } state_t;

   // A bit-count argument is legal only in 1..8.
   function automatic logic bits_ok(input logic [7:0] n);
      return (n >= 8'd1) && (n <= 8'd8);
   endfunction

endpackage

// File: rtl/owr_cmd_bridge.sv
// Decodes host command bytes into single 1-Wire master transactions and returns one
// response byte per command.
module owr_cmd_bridge
   import owr_pkg::*;
#(
   parameter int unsigned ARG_TIMEOUT_CYC = 50_000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx_vld,
   input  logic [7:0]   rx_dat,
   output logic         tx_vld,
   output logic [7:0]   tx_dat,
   input  logic         tx_rdy,
   output logic         ow_vld,
   input  logic         ow_rdy,
   output logic         ow_we,
   output logic [4:0]   ow_bits,
   output logic [7:0]   ow_wdat,
   input  logic [7:0]   ow_rdat,
   input  logic         ow_done,
   output logic         err_drop
);

   localparam int unsigned TMO_W = (ARG_TIMEOUT_CYC < 1) ? 1 : $clog2(ARG_TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(ARG_TIMEOUT_CYC);

   state_t               state_q, state_d;
   logic [BYTE_W-1:0]    op_q, op_d;
   logic                 have_n_q, have_n_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic                 tx_vld_q, tx_vld_d;
   logic [BYTE_W-1:0]    tx_dat_q, tx_dat_d;
   logic                 ow_vld_q, ow_vld_d;
   logic                 ow_we_q, ow_we_d;
   logic [BITS_W-1:0]    ow_bits_q, ow_bits_d;
   logic [BYTE_W-1:0]    ow_wdat_q, ow_wdat_d;
   logic                 err_drop_q, err_drop_d;

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= '0;
         have_n_q   <= 1'b0;
         tmo_q      <= '0;
         tx_vld_q   <= 1'b0;
         tx_dat_q   <= '0;
         ow_vld_q   <= 1'b0;
         ow_we_q    <= 1'b0;
         ow_bits_q  <= '0;
         ow_wdat_q  <= '0;
         err_drop_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         have_n_q   <= have_n_d;
         tmo_q      <= tmo_d;
         tx_vld_q   <= tx_vld_d;
         tx_dat_q   <= tx_dat_d;
         ow_vld_q   <= ow_vld_d;
         ow_we_q    <= ow_we_d;
         ow_bits_q  <= ow_bits_d;
         ow_wdat_q  <= ow_wdat_d;
         err_drop_q <= err_drop_d;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      have_n_d   = have_n_q;
      tmo_d      = '0;
      tx_vld_d   = tx_vld_q;
      tx_dat_d   = tx_dat_q;
      ow_vld_d   = ow_vld_q;
      ow_we_d    = ow_we_q;
      ow_bits_d  = ow_bits_q;
      ow_wdat_d  = ow_wdat_q;
      err_drop_d = err_drop_q;

      unique case (state_q)
         ST_IDLE: begin
            if (rx_vld) begin
               op_d     = rx_dat;
               have_n_d = 1'b0;
               case (rx_dat)
                  OP_RESET: begin
                     ow_we_d   = 1'b0;
                     ow_bits_d = '0;
                     ow_wdat_d = '0;
                     ow_vld_d  = 1'b1;
                     state_d   = ST_ISSUE;
                  end
                  OP_READ: begin
                     ow_we_d   = 1'b0;
                     ow_bits_d = BITS_W'(8);
                     ow_wdat_d = '0;
                     ow_vld_d  = 1'b1;
                     state_d   = ST_ISSUE;
                  end
                  OP_WRITE, OP_WRITE_BITS, OP_READ_BITS: begin
                     state_d = ST_GET_ARG;
                  end
                  default: begin
                     tx_dat_d = RSP_ERR;
                     tx_vld_d = 1'b1;
                     state_d  = ST_SEND;
                  end
               endcase
            end
         end

         ST_GET_ARG: begin
            if (rx_vld) begin
               case (op_q)
                  OP_WRITE: begin
                     ow_we_d   = 1'b1;
                     ow_bits_d = BITS_W'(8);
                     ow_wdat_d = rx_dat;
                     ow_vld_d  = 1'b1;
                     state_d   = ST_ISSUE;
                  end
                  OP_WRITE_BITS: begin
                     if (have_n_q) begin
                        ow_we_d   = 1'b1;
                        ow_wdat_d = rx_dat;
                        ow_vld_d  = 1'b1;
                        state_d   = ST_ISSUE;
                     end else if (bits_ok(rx_dat)) begin
                        ow_bits_d = rx_dat[BITS_W-1:0];
                        have_n_d  = 1'b1;
                     end else begin
                        tx_dat_d = RSP_ERR;
                        tx_vld_d = 1'b1;
                        state_d  = ST_SEND;
                     end
                  end
                  OP_READ_BITS: begin
                     if (bits_ok(rx_dat)) begin
                        ow_we_d   = 1'b0;
                        ow_bits_d = rx_dat[BITS_W-1:0];
                        ow_wdat_d = '0;
                        ow_vld_d  = 1'b1;
                        state_d   = ST_ISSUE;
                     end else begin
                        tx_dat_d = RSP_ERR;
                        tx_vld_d = 1'b1;
                        state_d  = ST_SEND;
                     end
                  end
                  default: begin
                     tx_dat_d = RSP_ERR;
                     tx_vld_d = 1'b1;
                     state_d  = ST_SEND;
                  end
               endcase
            end else if (tmo_q == TMO_MAX) begin
               tx_dat_d = RSP_ERR;
               tx_vld_d = 1'b1;
               state_d  = ST_SEND;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         ST_ISSUE: begin
            if (ow_rdy) begin
               ow_vld_d = 1'b0;
               state_d  = ST_WAIT_DONE;
            end
         end

         ST_WAIT_DONE: begin
            if (ow_done) begin
               if (op_q == OP_RESET) begin
                  tx_dat_d = {7'b0, ow_rdat[0]};
               end else if (ow_we_q) begin
                  tx_dat_d = RSP_ACK;
               end else begin
                  tx_dat_d = ow_rdat;
               end
               tx_vld_d = 1'b1;
               state_d  = ST_SEND;
            end
         end

         ST_SEND: begin
            if (tx_rdy) begin
               tx_vld_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Bytes arriving while a command is in flight are lost.
      if (rx_vld && (state_q != ST_IDLE) && (state_q != ST_GET_ARG)) begin
         err_drop_d = 1'b1;
      end
   end

   assign tx_vld   = tx_vld_q;
   assign tx_dat   = tx_dat_q;
   assign ow_vld   = ow_vld_q;
   assign ow_we    = ow_we_q;
   assign ow_bits  = ow_bits_q;
   assign ow_wdat  = ow_wdat_q;
   assign err_drop = err_drop_q;

endmodule

// File: tb/tb_owr_cmd_bridge.sv
// Scoreboard bench for owr_cmd_bridge with a behavioural 1-Wire slave model.
module tb_owr_cmd_bridge;

   localparam int unsigned TMO = 200;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_vld;
   logic [7:0] rx_dat;
   logic       tx_vld;
   logic [7:0] tx_dat;
   logic       tx_rdy;
   logic       ow_vld;
   logic       ow_rdy;
   logic       ow_we;
   logic [4:0] ow_bits;
   logic [7:0] ow_wdat;
   logic [7:0] ow_rdat;
   logic       ow_done;
   logic       err_drop;

   owr_cmd_bridge #(.ARG_TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst),
      .rx_vld(rx_vld), .rx_dat(rx_dat),
      .tx_vld(tx_vld), .tx_dat(tx_dat), .tx_rdy(tx_rdy),
      .ow_vld(ow_vld), .ow_rdy(ow_rdy), .ow_we(ow_we), .ow_bits(ow_bits),
      .ow_wdat(ow_wdat), .ow_rdat(ow_rdat), .ow_done(ow_done),
      .err_drop(err_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       we;
      logic [4:0] bits;
      logic [7:0] wdat;
   } ow_exp_t;

   ow_exp_t    exp_ow[$];
   logic [7:0] exp_tx[$];
   int checks = 0;
   int errors = 0;
   int ow_hs = 0;
   int ow_pushes = 0;

   logic       slave_hold = 1'b0;
   logic       slave_present = 1'b1;
   logic [7:0] slave_rdat = 8'h00;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic push_ow(input logic we, input logic [4:0] bits, input logic [7:0] wdat);
      ow_exp_t e;
      e.we = we; e.bits = bits; e.wdat = wdat;
      exp_ow.push_back(e);
      ow_pushes++;
   endtask

   // Called at posedge+1; presents one byte for exactly one cycle.
   task automatic send_byte(input logic [7:0] b);
      rx_vld = 1'b1;
      rx_dat = b;
      @(posedge clk); #1;
      rx_vld = 1'b0;
      rx_dat = 8'h00;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while ((exp_tx.size() != 0 || exp_ow.size() != 0) && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk(name, exp_tx.size() + exp_ow.size(), 0);
      @(posedge clk); #1;
   endtask

   // TX monitor: compare every accepted response byte with the scoreboard.
   logic [7:0] mon_tx;
   always @(negedge clk) begin
      if (!rst && tx_vld && tx_rdy) begin
         if (exp_tx.size() == 0) begin
            chk("tx_unexpected", {24'h0, tx_dat}, 32'h100);
         end else begin
            mon_tx = exp_tx.pop_front();
            chk("tx_dat", tx_dat, mon_tx);
         end
      end
   end

   // 1-Wire request monitor.
   ow_exp_t mon_ow;
   always @(negedge clk) begin
      if (!rst && ow_vld && ow_rdy) begin
         ow_hs++;
         if (exp_ow.size() == 0) begin
            chk("ow_unexpected", ow_bits, 32'h100);
         end else begin
            mon_ow = exp_ow.pop_front();
            chk("ow_bits", ow_bits, mon_ow.bits);
            if (mon_ow.bits != 5'd0) chk("ow_we", ow_we, mon_ow.we);
            if (mon_ow.we) chk("ow_wdat", ow_wdat, mon_ow.wdat);
         end
      end
   end

   // Slave model: completes each accepted transaction a few cycles later.
   logic [4:0] slv_bits;
   initial begin
      ow_done = 1'b0;
      ow_rdat = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst && ow_vld && ow_rdy) begin
            slv_bits = ow_bits;
            @(posedge clk);
            repeat (3) @(posedge clk);
            #1;
            if (!slave_hold) begin
               ow_rdat = (slv_bits == 5'd0) ? {7'b0, slave_present} : slave_rdat;
               ow_done = 1'b1;
               @(posedge clk); #1;
               ow_done = 1'b0;
            end
         end
      end
   end

   initial begin
      int bad;
      rst    = 1'b1;
      rx_vld = 1'b0;
      rx_dat = 8'h00;
      tx_rdy = 1'b1;
      ow_rdy = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx_vld", tx_vld, 0);
      chk("rst_tx_dat", tx_dat, 0);
      chk("rst_ow_vld", ow_vld, 0);
      chk("rst_ow_bits", ow_bits, 0);
      chk("rst_ow_wdat", ow_wdat, 0);
      chk("rst_err_drop", err_drop, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // RESET with device present, then absent.
      slave_present = 1'b1;
      push_ow(1'b0, 5'd0, 8'h00); exp_tx.push_back(8'h01);
      send_byte(8'h01);
      chk("reset_issue_lat", ow_vld, 1);
      wait_idle("reset_p_done", 200);
      slave_present = 1'b0;
      push_ow(1'b0, 5'd0, 8'h00); exp_tx.push_back(8'h00);
      send_byte(8'h01);
      wait_idle("reset_np_done", 200);

      // WRITE 0xA5.
      push_ow(1'b1, 5'd8, 8'hA5); exp_tx.push_back(8'hAA);
      send_byte(8'h02);
      chk("write_no_early_vld", ow_vld, 0);
      send_byte(8'hA5);
      chk("write_issue_lat", ow_vld, 1);
      wait_idle("write_done", 200);

      // READ returning 0x3C.
      slave_rdat = 8'h3C;
      push_ow(1'b0, 5'd8, 8'h00); exp_tx.push_back(8'h3C);
      send_byte(8'h03);
      wait_idle("read_done", 200);

      // Unknown opcode.
      exp_tx.push_back(8'hEE);
      send_byte(8'h7F);
      chk("badop_tx_lat", tx_vld, 1);
      wait_idle("badop_done", 200);

      // WRITE_BITS with n=9 is rejected immediately.
      exp_tx.push_back(8'hEE);
      send_byte(8'h04);
      send_byte(8'h09);
      chk("wbits_bad_tx_lat", tx_vld, 1);
      wait_idle("wbits_bad_done", 200);

      // WRITE_BITS n=3 data 0x05.
      push_ow(1'b1, 5'd3, 8'h05); exp_tx.push_back(8'hAA);
      send_byte(8'h04);
      send_byte(8'h03);
      send_byte(8'h05);
      chk("wbits_issue_lat", ow_vld, 1);
      wait_idle("wbits_done", 200);

      // READ_BITS n=8 (upper boundary) and n=0 (rejected).
      slave_rdat = 8'h15;
      push_ow(1'b0, 5'd8, 8'h00); exp_tx.push_back(8'h15);
      send_byte(8'h05);
      send_byte(8'h08);
      wait_idle("rbits_done", 200);
      exp_tx.push_back(8'hEE);
      send_byte(8'h05);
      send_byte(8'h00);
      wait_idle("rbits_bad_done", 200);

      // Argument timeout.
      exp_tx.push_back(8'hEE);
      send_byte(8'h02);
      bad = 0;
      repeat (150) begin
         if (tx_vld !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      chk("tmo_not_early", bad, 0);
      wait_idle("tmo_done", 200);

      // Backpressure on TX plus a dropped byte.
      slave_rdat = 8'hC3;
      tx_rdy = 1'b0;
      push_ow(1'b0, 5'd8, 8'h00); exp_tx.push_back(8'hC3);
      send_byte(8'h03);
      bad = 0;
      while (tx_vld !== 1'b1 && bad < 50) begin
         @(posedge clk); #1;
         bad++;
      end
      chk("bp_tx_seen", tx_vld, 1);
      send_byte(8'h01);
      bad = 0;
      repeat (100) begin
         if (tx_vld !== 1'b1 || tx_dat !== 8'hC3) bad++;
         @(posedge clk); #1;
      end
      chk("bp_tx_stable", bad, 0);
      chk("err_drop_set", err_drop, 1);
      tx_rdy = 1'b1;
      wait_idle("bp_done", 200);
      repeat (20) @(posedge clk);
      #1;
      chk("drop_no_cmd", ow_hs, ow_pushes);

      // Reset while waiting for completion.
      slave_hold = 1'b1;
      push_ow(1'b0, 5'd8, 8'h00);
      send_byte(8'h03);
      wait_idle("rst_issue_done", 50);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_tx_vld", tx_vld, 0);
      chk("midrst_tx_dat", tx_dat, 0);
      chk("midrst_ow_vld", ow_vld, 0);
      chk("midrst_ow_bits", ow_bits, 0);
      chk("midrst_err_drop", err_drop, 0);
      repeat (8) @(posedge clk);
      #1;
      slave_hold = 1'b0;
      slave_rdat = 8'h5A;
      push_ow(1'b0, 5'd8, 8'h00); exp_tx.push_back(8'h5A);
      send_byte(8'h03);
      wait_idle("post_rst_read", 200);

      repeat (10) @(posedge clk);
      #1;
      chk("ow_hs_total", ow_hs, ow_pushes);
      chk("tx_q_empty", exp_tx.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/owr_cmd_bridge.md
# owr_cmd_bridge

Command sequencer between the UART byte receiver/transmitter and `onewire_master` in `top`. Decodes opcode/argument bytes arriving from the host over UART into single 1-Wire master transactions (bus reset/presence, write byte/bits, read byte/bits). Returns one response byte per command to the UART transmitter. Replaces the current "echo on any byte" behaviour of `top`.

## Interface
Parameters:
- `ARG_TIMEOUT_CYC`, default 50_000 (5 ms at 10 MHz): max cycles waiting for an argument byte before the command is aborted.

Ports:
- `clk`  in  1  system clock (`clk_10` in `top`).
- `rst`  in  1  synchronous, active-high reset.
- `rx_vld`  in  1  one-cycle strobe: `rx_dat` holds a received UART byte.
- `rx_dat`  in  8  received byte.
- `tx_vld`  out  1  response byte valid; held until accepted.
- `tx_dat`  out  8  response byte; stable while `tx_vld`.
- `tx_rdy`  in  1  UART TX accepts the byte on `tx_vld & tx_rdy`.
- `ow_vld`  out  1  1-Wire transaction request; held until accepted.
- `ow_rdy`  in  1  master accepts on `ow_vld & ow_rdy`.
- `ow_we`  out  1  1 = write, 0 = read; ignored when `ow_bits`=0.
- `ow_bits`  out  5  bit count 1..8; 0 = bus reset + presence detect.
- `ow_wdat`  out  8  write data, LSB first on the wire.
- `ow_rdat`  in  8  read data / presence (`ow_rdat[0]`=1 means device present); valid when `ow_done`.
- `ow_done`  in  1  one-cycle pulse when the accepted transaction completes.
- `err_drop`  out  1  sticky: a byte arrived while busy and was dropped; cleared only by `rst`.

## Operation
- Opcodes (all others → response `RSP_ERR`=0xEE, no bus activity):
  - 0x01 RESET: `ow_bits`=0 → response 0x00 no presence / 0x01 presence.
  - 0x02 WRITE, arg data: `ow_we`=1, `ow_bits`=8 → response `RSP_ACK`=0xAA.
  - 0x03 READ: `ow_we`=0, `ow_bits`=8 → response `ow_rdat`.
  - 0x04 WRITE_BITS, arg1 n (1..8), arg2 data → 0xAA; n outside 1..8 → 0xEE, no bus activity.
  - 0x05 READ_BITS, arg n (1..8) → `ow_rdat` (unused high bits as the master delivers); bad n → 0xEE.
- FSM: IDLE → (opcode needing args) GET_ARG → ISSUE → WAIT_DONE → SEND → IDLE. Zero-arg opcodes go IDLE → ISSUE. Error paths go directly to SEND.
- GET_ARG: timeout counter clears on each accepted byte; on reaching `ARG_TIMEOUT_CYC` → SEND with 0xEE.
- ISSUE: `ow_vld`=1 with `ow_we/ow_bits/ow_wdat` stable until handshake; then WAIT_DONE.
- WAIT_DONE: on `ow_done` latch response byte → SEND. No timeout (master guarantees completion).
- SEND: `tx_vld`=1 until `tx_rdy`; then IDLE.
- `rx_vld` outside IDLE/GET_ARG: byte dropped, `err_drop` set.

## Timing
- Reset values: `tx_vld`=0, `tx_dat`=0, `ow_vld`=0, `ow_we`=0, `ow_bits`=0, `ow_wdat`=0, `err_drop`=0, state IDLE, timeout counter 0.
- Last byte of command accepted in cycle n → `ow_vld`=1 in n+1.
- `ow_done` in cycle m → `tx_vld`=1 with response in m+1.
- Error/unknown opcode in cycle n → `tx_vld` in n+1.
- Handshake accepted in cycle k → `ow_vld` / `tx_vld` low in k+1; `ow_rdy` may already be high when `ow_vld` rises (same-cycle accept allowed).
- `ow_done` outside WAIT_DONE is ignored.
- `rst` mid-transaction: all outputs to reset values next cycle; partial command discarded; master is reset by the same `rst`.
- Timeout counter width = $clog2(ARG_TIMEOUT_CYC+1); it saturates, never wraps.

## Structure
- `owr_pkg`: opcode localparams (`OP_RESET`..`OP_READ_BITS`), `RSP_ACK`, `RSP_ERR`, FSM state enum.
- Single flat module; no sub-module (response register is part of the SEND state).

## Test plan
- RESET with slave model present: rx 0x01 → `ow_bits`=0 issued; response 0x01 on tx.
- WRITE: rx 0x02, 0xA5 → one master write with `ow_wdat`=0xA5, `ow_bits`=8, `ow_we`=1; response 0xAA.
- READ: slave model returns 0x3C → rx 0x03 → tx 0x3C, `ow_vld` exactly one handshake.
- Errors: rx 0x7F → tx 0xEE; rx 0x04, 0x09 → tx 0xEE, no `ow_vld`; rx 0x02 then silence `ARG_TIMEOUT_CYC` cycles → tx 0xEE, state IDLE.
- Backpressure/drop: hold `tx_rdy`=0 for 100 cycles → `tx_dat` stable; send a byte meanwhile → `err_drop`=1 and that byte produces no command.
- Reset mid-WAIT_DONE: assert `rst` 1 cycle → all outputs at reset values next cycle; following 0x03 completes normally.
